// File: rtl/log_scheduler.sv
// Round-robin front end that shares one pipelined natural-log unit among N_REQ requesters.
// Operands are pre-offset by -1.0 (Q3.12) and results return on a single tagged response bus.
module log_scheduler #(
    parameter int N_REQ       = 4,
    parameter int W           = 16,
    parameter int LOG_LATENCY = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W-1:0]        req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [W-1:0]              log_data,
    input  logic [W-1:0]              log_result,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [W-1:0]              rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic signed [W-1:0] ONE      = signed'(W'(1) << (W - 4));
    localparam logic        [W-1:0] ERR_CODE = W'(1) << (W - 1);

    function automatic logic signed [W-1:0] offset_operand(input logic signed [W-1:0] x);
        return x - ONE;
    endfunction

    // ln() is undefined for zero and negative operands
    function automatic logic domain_err(input logic signed [W-1:0] x);
        return x[W-1] || (x == '0);
    endfunction

    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        idx;
    logic                   grant_any;
    int                     scan;
    logic signed [W-1:0]    op_x_p0;
    logic                   op_err_p0;

    logic [LOG_LATENCY:0]   tag_vld_p;
    logic [LOG_LATENCY:0]   tag_err_p;
    logic [ID_W-1:0]        tag_id_p [0:LOG_LATENCY];

    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        scan      = 0;
        if (RST) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan = int'(ptr) + k;
                if (scan >= N_REQ) scan = scan - N_REQ;
                idx = ID_W'(scan);
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = idx;
                end
            end
        end
        if (grant_any) req_ready[grant_id] = 1'b1;
    end

    assign op_x_p0   = signed'(req_data[int'(grant_id)*W +: W]);
    assign op_err_p0 = domain_err(op_x_p0);

    // Stage 0: issue to the log unit; tag pipeline tracks the operation to the response stage
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ptr       <= '0;
            log_data  <= '0;
            tag_vld_p <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (grant_any)
                ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            log_data  <= (grant_any && !op_err_p0) ? W'(offset_operand(op_x_p0)) : '0;
            tag_vld_p <= {tag_vld_p[LOG_LATENCY-1:0], grant_any};
            // Response stage: log_result lines up with the final tag stage
            rsp_valid <= tag_vld_p[LOG_LATENCY];
            rsp_id    <= tag_vld_p[LOG_LATENCY] ? tag_id_p[LOG_LATENCY] : '0;
            rsp_err   <= tag_vld_p[LOG_LATENCY] && tag_err_p[LOG_LATENCY];
            if (!tag_vld_p[LOG_LATENCY])
                rsp_data <= '0;
            else
                rsp_data <= tag_err_p[LOG_LATENCY] ? ERR_CODE : log_result;
        end
    end

    always_ff @(posedge CLK) begin
        tag_err_p   <= {tag_err_p[LOG_LATENCY-1:0], grant_any && op_err_p0};
        tag_id_p[0] <= grant_id;
        for (int j = 1; j <= LOG_LATENCY; j++)
            tag_id_p[j] <= tag_id_p[j-1];
    end

    assign busy = (|tag_vld_p) || rsp_valid;

endmodule

// File: tb/tb_log_scheduler.sv
// Scoreboard bench for log_scheduler: default configuration plus a 2-requester, latency-4 instance.
module tb_log_scheduler;

    logic        CLK;
    logic        RST;
    int          cyc;
    int          n_checks;
    int          n_fail;
    bit          mon_en;

    logic [3:0]  req_valid_a;
    logic [63:0] req_data_a;
    logic [3:0]  req_ready_a;
    logic [15:0] log_data_a, log_result_a, rsp_data_a;
    logic        rsp_valid_a, rsp_err_a, busy_a;
    logic [1:0]  rsp_id_a;
    logic [15:0] lr_a [0:1];

    logic [1:0]  req_valid_b;
    logic [31:0] req_data_b;
    logic [1:0]  req_ready_b;
    logic [15:0] log_data_b, log_result_b, rsp_data_b;
    logic        rsp_valid_b, rsp_err_b, busy_b;
    logic [0:0]  rsp_id_b;
    logic [15:0] lr_b [0:3];

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb_a[$];
    exp_t sb_b[$];

    log_scheduler #(.N_REQ(4), .W(16), .LOG_LATENCY(2)) dut_a (
        .CLK(CLK), .RST(RST), .req_valid(req_valid_a), .req_data(req_data_a),
        .req_ready(req_ready_a), .log_data(log_data_a), .log_result(log_result_a),
        .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_data(rsp_data_a),
        .rsp_err(rsp_err_a), .busy(busy_a));

    log_scheduler #(.N_REQ(2), .W(16), .LOG_LATENCY(4)) dut_b (
        .CLK(CLK), .RST(RST), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .log_data(log_data_b), .log_result(log_result_b),
        .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b),
        .rsp_err(rsp_err_b), .busy(busy_b));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Stand-in log unit: ln(2.0) for input 1.0, otherwise a bitwise complement
    function automatic logic [15:0] ln_model(input logic [15:0] d);
        return (d == 16'h1000) ? 16'h0B17 : ~d;
    endfunction

    always @(posedge CLK) begin
        lr_a[0] <= ln_model(log_data_a);
        lr_a[1] <= lr_a[0];
        lr_b[0] <= ln_model(log_data_b);
        for (int i = 1; i < 4; i++) lr_b[i] <= lr_b[i-1];
    end
    assign log_result_a = lr_a[1];
    assign log_result_b = lr_b[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (rsp_valid_a) begin
                if (sb_a.size() == 0) begin
                    check("a_rsp_valid_unexpected", 32'(rsp_valid_a), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_a.pop_front();
                    check("a_rsp_id", 32'(rsp_id_a), 32'(e.id));
                    check("a_rsp_data", 32'(rsp_data_a), 32'(e.data));
                    check("a_rsp_err", 32'(rsp_err_a), 32'(e.err));
                    check("a_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("a_rsp_idle", {13'd0, rsp_id_a, rsp_data_a, rsp_err_a}, 32'd0);
            end
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            if (rsp_valid_b) begin
                if (sb_b.size() == 0) begin
                    check("b_rsp_valid_unexpected", 32'(rsp_valid_b), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_b.pop_front();
                    check("b_rsp_id", 32'(rsp_id_b), 32'(e.id));
                    check("b_rsp_data", 32'(rsp_data_b), 32'(e.data));
                    check("b_rsp_err", 32'(rsp_err_b), 32'(e.err));
                    check("b_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("b_rsp_idle", {14'd0, rsp_id_b, rsp_data_b, rsp_err_b}, 32'd0);
            end
        end
    end

    // Called at a negedge with inputs already applied; returns at the following negedge.
    task automatic accept_a(input int id, input logic [15:0] exp_ld, input logic [15:0] exp_rsp,
                            input logic err, input bit track);
        #1;
        check("a_grant", 32'(req_ready_a), 32'd1 << id);
        if (track) sb_a.push_back('{id: id, data: exp_rsp, err: err, cyc: cyc + 4});
        @(posedge CLK); #1;
        check("a_log_data", 32'(log_data_a), 32'(exp_ld));
        @(negedge CLK);
    endtask

    task automatic accept_b(input int id, input logic [15:0] exp_ld, input logic [15:0] exp_rsp);
        #1;
        check("b_grant", 32'(req_ready_b), 32'd1 << id);
        sb_b.push_back('{id: id, data: exp_rsp, err: 1'b0, cyc: cyc + 6});
        @(posedge CLK); #1;
        check("b_log_data", 32'(log_data_b), 32'(exp_ld));
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        req_valid_a = '0;
        req_valid_b = '0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req_valid_a = 4'hF;
        req_valid_b = 2'h3;
        #1;
        check("rst_ready_a", 32'(req_ready_a), 32'd0);
        check("rst_ready_b", 32'(req_ready_b), 32'd0);
        @(posedge CLK); #1;
        check("rst_out_a", {10'd0, log_data_a, rsp_valid_a, rsp_err_a, busy_a, rsp_id_a}, 32'd0);
        check("rst_rsp_data_a", 32'(rsp_data_a), 32'd0);
        check("rst_out_b", {11'd0, log_data_b, rsp_valid_b, rsp_err_b, busy_b, rsp_id_b}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        req_valid_a = '0;
        req_valid_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        mon_en = 1'b0;
        RST = 1'b0;
        req_valid_a = '0;
        req_data_a = '0;
        req_valid_b = '0;
        req_data_b = '0;
        @(negedge CLK);
        do_reset();
        mon_en = 1'b1;

        // single request: 2.0 -> ln = 0x0B17
        req_data_a = {16'h0, 16'h0, 16'h0, 16'h2000};
        req_valid_a = 4'b0001;
        accept_a(0, 16'h1000, 16'h0B17, 1'b0, 1'b1);
        req_valid_a = '0;
        @(posedge CLK); #1;
        check("a_log_data_idle", 32'(log_data_a), 32'd0);
        @(negedge CLK);
        idle(6);

        // saturation
        do_reset();
        req_data_a = {16'h7FFF, 16'h0800, 16'h3000, 16'h1800};
        req_valid_a = 4'hF;
        for (int r = 0; r < 2; r++) begin
            accept_a(0, 16'h0800, 16'hF7FF, 1'b0, 1'b1);
            accept_a(1, 16'h2000, 16'hDFFF, 1'b0, 1'b1);
            accept_a(2, 16'hF800, 16'h07FF, 1'b0, 1'b1);
            accept_a(3, 16'h6FFF, 16'h9000, 1'b0, 1'b1);
        end
        req_valid_a = '0;
        repeat (3) @(posedge CLK);
        #1 check("a_busy_tail", 32'(busy_a), 32'd1);
        @(posedge CLK);
        #1 check("a_busy_clear", 32'(busy_a), 32'd0);
        @(negedge CLK);
        idle(4);

        // fairness
        do_reset();
        req_data_a = {16'h4000, 16'h2000, 16'h0, 16'h1000};
        req_valid_a = 4'b0101;
        accept_a(0, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        accept_a(2, 16'h1000, 16'h0B17, 1'b0, 1'b1);
        accept_a(0, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        accept_a(2, 16'h1000, 16'h0B17, 1'b0, 1'b1);
        req_valid_a = 4'b1101;
        accept_a(3, 16'h3000, 16'hCFFF, 1'b0, 1'b1);
        accept_a(0, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        idle(6);

        // domain errors (pointer now at 1)
        req_data_a = {16'h8000, 16'h0, 16'h0000, 16'hFFFF};
        req_valid_a = 4'b0010;
        accept_a(1, 16'h0000, 16'h8000, 1'b1, 1'b1);
        req_valid_a = 4'b1000;
        accept_a(3, 16'h0000, 16'h8000, 1'b1, 1'b1);
        req_valid_a = 4'b0001;
        accept_a(0, 16'h0000, 16'h8000, 1'b1, 1'b1);
        idle(6);

        // reset mid-flight
        do_reset();
        req_data_a = {16'h7FFF, 16'h0800, 16'h3000, 16'h1800};
        req_valid_a = 4'hF;
        accept_a(0, 16'h0800, 16'hF7FF, 1'b0, 1'b0);
        accept_a(1, 16'h2000, 16'hDFFF, 1'b0, 1'b0);
        accept_a(2, 16'hF800, 16'h07FF, 1'b0, 1'b0);
        RST = 1'b0;
        req_valid_a = '0;
        @(posedge CLK); #1;
        check("mid_rst_out", {11'd0, log_data_a, rsp_valid_a, rsp_err_a, busy_a, rsp_id_a}, 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data_a), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        idle(6);
        req_valid_a = 4'hF;
        accept_a(0, 16'h0800, 16'hF7FF, 1'b0, 1'b1);
        idle(6);

        // second configuration: two requesters, latency 4
        do_reset();
        req_data_b = {16'h3000, 16'h2000};
        req_valid_b = 2'b11;
        accept_b(0, 16'h1000, 16'h0B17);
        accept_b(1, 16'h2000, 16'hDFFF);
        accept_b(0, 16'h1000, 16'h0B17);
        accept_b(1, 16'h2000, 16'hDFFF);
        idle(10);

        check("a_scoreboard_drained", 32'(sb_a.size()), 32'd0);
        check("b_scoreboard_drained", 32'(sb_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
